// File: rtl/mdma_desc_fifo_pkg.sv
// Shared constants and types for the descriptor-request FIFO controller and its output stage.
package mdma_desc_fifo_pkg;

   localparam int unsigned WR_ENG_FIFO_DEPTH           = 512;
   localparam int unsigned DESC_REQ_FIFO_RAM_DATA_BITS = 48;
   localparam int unsigned PTR_W                       = $clog2(WR_ENG_FIFO_DEPTH) + 1;

   // MSB is the wrap bit; low bits index the RAM.
   typedef logic [PTR_W-1:0] ptr_t;

   typedef struct packed {
      logic [DESC_REQ_FIFO_RAM_DATA_BITS-1:0] dat;
      logic                                   sbe;
      logic                                   dbe;
   } ost_entry_t;

endpackage

// File: rtl/mdma_48bx512_48bwe_ram_if.sv
// Port bundle between the descriptor-request FIFO controller (m) and its 48b x 512 RAM (s).
interface mdma_48bx512_48bwe_ram_if #(
   parameter int unsigned AW = 9,
   parameter int unsigned DW = 48
);
   logic [AW-1:0] wadr;
   logic          wen;
   logic [DW-1:0] wdat;
   logic          ren;
   logic [AW-1:0] radr;
   logic [DW-1:0] rdat;
   logic          rsbe;
   logic          rdbe;

   modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);
   modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);
endinterface

// File: rtl/mdma_desc_fifo_ostage.sv
// Small register FIFO holding RAM returns ahead of the pop port. A return arriving while the
// stage is empty and the consumer is ready passes straight through without occupying a slot.
module mdma_desc_fifo_ostage
   import mdma_desc_fifo_pkg::*;
#(
   parameter int unsigned  OST_D = 2,
   localparam int unsigned OCC_W = $clog2(OST_D + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_vld,
   input  ost_entry_t       in_ent,
   output logic             out_vld,
   input  logic             out_rdy,
   output ost_entry_t       out_ent,
   output logic [OCC_W-1:0] occ
);

   localparam int unsigned         IDX_W    = (OST_D > 1) ? $clog2(OST_D) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(OST_D - 1);
   localparam logic [OCC_W-1:0]    FULL_OCC = OCC_W'(OST_D);

   ost_entry_t       mem_q [OST_D];
   logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
   logic [OCC_W-1:0] occ_q;
   logic             empty, bypass, wr_en, rd_en;

   function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   endfunction

   always_comb begin
      empty   = (occ_q == '0);
      out_vld = !empty || in_vld;
      out_ent = empty ? in_ent : mem_q[rd_idx_q];
      bypass  = empty && in_vld && out_rdy;
      wr_en   = in_vld && !bypass && !clr;
      rd_en   = !empty && out_rdy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         occ_q    <= '0;
      end else if (clr) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         occ_q    <= '0;
      end else begin
         if (wr_en) wr_idx_q <= nxt_idx(wr_idx_q);
         if (rd_en) rd_idx_q <= nxt_idx(rd_idx_q);
         occ_q <= occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx_q] <= in_ent;
   end

   assign occ = occ_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      wr_en |-> (occ_q < FULL_OCC));

endmodule

// File: rtl/mdma_desc_req_fifo_ctl.sv
// Sequences the descriptor-request RAM as a FIFO: push stream -> RAM writes, RAM reads ->
// prefetched pop stream, with occupancy tracking and ECC error reporting.
module mdma_desc_req_fifo_ctl
   import mdma_desc_fifo_pkg::*;
#(
   parameter int unsigned  DEPTH  = WR_ENG_FIFO_DEPTH,
   parameter int unsigned  DATA_W = DESC_REQ_FIFO_RAM_DATA_BITS,
   parameter int unsigned  RD_LAT = 1,
   localparam int unsigned OST_D  = RD_LAT + 1,
   localparam int unsigned AW     = $clog2(DEPTH),
   localparam int unsigned CW     = $clog2(DEPTH) + 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [DATA_W-1:0]    in_dat,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [DATA_W-1:0]    out_dat,
   output logic                 out_sbe,
   output logic                 out_dbe,
   output logic [CW-1:0]        count,
   mdma_48bx512_48bwe_ram_if.m  ram,
   output logic                 err_dbe,
   output logic [15:0]          sbe_cnt
);

   localparam int unsigned      OCC_W     = $clog2(OST_D + 1);
   localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(DEPTH);
   localparam logic [OCC_W:0]   OST_SLOTS = (OCC_W + 1)'(OST_D);

   logic [AW:0]       wptr_q, rptr_q, ram_cnt;
   logic              rdy_en_q;
   logic              full, push, ren, pop, ret_vld;
   logic [RD_LAT-1:0] infl_q, infl_d;
   logic [OCC_W-1:0]  ost_occ, infl_cnt;
   logic [OCC_W:0]    used;
   ost_entry_t        ret_ent, head;
   logic [CW-1:0]     count_q, count_d;
   logic              err_dbe_q;
   logic [15:0]       sbe_cnt_q;

   always_comb begin
      ram_cnt = wptr_q - rptr_q;
      full    = (ram_cnt == DEPTH_CNT);
      // rdy_en_q holds in_rdy low through reset and releases it one cycle after.
      in_rdy  = rdy_en_q && !full && !flush;
      push    = in_vld && in_rdy;

      infl_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + OCC_W'(infl_q[i]);
      used = {1'b0, ost_occ} + {1'b0, infl_cnt};

      // ram_cnt excludes this cycle's push, so a word is never read in the cycle it is written.
      ren = (ram_cnt != '0) && (used < OST_SLOTS) && !flush;

      infl_d    = '0;
      infl_d[0] = ren;
      for (int i = 1; i < RD_LAT; i++) infl_d[i] = infl_q[i-1];
      if (flush) infl_d = '0;

      ret_vld = infl_q[RD_LAT-1] && !flush;
      ret_ent = '{dat: ram.rdat, sbe: ram.rsbe, dbe: ram.rdbe};
   end

   assign ram.wen  = push;
   assign ram.wadr = wptr_q[AW-1:0];
   assign ram.wdat = in_dat;
   assign ram.ren  = ren;
   assign ram.radr = rptr_q[AW-1:0];

   mdma_desc_fifo_ostage #(
      .OST_D (OST_D)
   ) u_ostage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .in_vld  (ret_vld),
      .in_ent  (ret_ent),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_ent (head),
      .occ     (ost_occ)
   );

   assign out_dat = head.dat;
   assign out_sbe = head.sbe;
   assign out_dbe = head.dbe;
   assign pop     = out_vld && out_rdy;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) count_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q  <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         infl_q    <= '0;
         count_q   <= '0;
         err_dbe_q <= 1'b0;
         sbe_cnt_q <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + (AW + 1)'(1);
            if (ren)  rptr_q <= rptr_q + (AW + 1)'(1);
         end
         infl_q  <= infl_d;
         count_q <= count_d;
         // Error status survives flush; only reset clears it.
         if (pop && head.dbe) err_dbe_q <= 1'b1;
         if (pop && head.sbe && (sbe_cnt_q != 16'hFFFF)) sbe_cnt_q <= sbe_cnt_q + 16'd1;
      end
   end

   assign count   = count_q;
   assign err_dbe = err_dbe_q;
   assign sbe_cnt = sbe_cnt_q;

   a_no_wen_full: assert property (@(posedge clk) disable iff (!rst_n)
      ram.wen |-> !full);
   a_no_ren_empty: assert property (@(posedge clk) disable iff (!rst_n)
      ram.ren |-> (ram_cnt != '0));

endmodule

// File: tb/tb_mdma_desc_req_fifo_ctl.sv
// Directed bench for the descriptor-request FIFO controller with a behavioural 1-cycle RAM.
module tb_mdma_desc_req_fifo_ctl;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 48;
   localparam int unsigned CW = 11;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_vld, in_rdy, out_vld, out_rdy, out_sbe, out_dbe, err_dbe;
   logic [DW-1:0] in_dat, out_dat;
   logic [CW-1:0] count;
   logic [15:0]   sbe_cnt;
   logic          ecc_en;
   logic [DW-1:0] mem [512];
   int unsigned   vec_cnt = 0;
   int unsigned   miss_cnt = 0;

   mdma_48bx512_48bwe_ram_if #(.AW(AW), .DW(DW)) ram_bus ();

   mdma_desc_req_fifo_ctl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_dat  (in_dat),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_dat (out_dat),
      .out_sbe (out_sbe),
      .out_dbe (out_dbe),
      .count   (count),
      .ram     (ram_bus),
      .err_dbe (err_dbe),
      .sbe_cnt (sbe_cnt)
   );

   always #5 clk = ~clk;

   // RAM with one cycle read latency; ECC flags injected on data values 5 (SBE) and 9 (DBE).
   always @(posedge clk) begin
      if (ram_bus.wen) mem[ram_bus.wadr] <= ram_bus.wdat;
      if (ram_bus.ren) begin
         ram_bus.rdat <= mem[ram_bus.radr];
         ram_bus.rsbe <= ecc_en && (mem[ram_bus.radr] == 48'd5);
         ram_bus.rdbe <= ecc_en && (mem[ram_bus.radr] == 48'd9);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int acc, exp_i, pushed, popped, model, e;
      rst_n = 1'b0; flush = 1'b0; in_vld = 1'b1; in_dat = 48'hDEAD;
      out_rdy = 1'b0; ecc_en = 1'b0;

      // Reset values, with a push attempted during reset
      tick(); tick(); settle();
      chk("rst_in_rdy", 64'(in_rdy), 0);
      chk("rst_out_vld", 64'(out_vld), 0);
      chk("rst_count", 64'(count), 0);
      chk("rst_wen", 64'(ram_bus.wen), 0);
      chk("rst_ren", 64'(ram_bus.ren), 0);
      chk("rst_wadr", 64'(ram_bus.wadr), 0);
      chk("rst_radr", 64'(ram_bus.radr), 0);
      chk("rst_err_dbe", 64'(err_dbe), 0);
      chk("rst_sbe_cnt", 64'(sbe_cnt), 0);
      in_vld = 1'b0;
      rst_n  = 1'b1;
      tick(); settle();
      chk("first_in_rdy", 64'(in_rdy), 1);
      chk("first_out_vld", 64'(out_vld), 0);

      // Single word latency
      in_vld = 1'b1; in_dat = 48'h123456789ABC; settle();
      chk("t0_wen", 64'(ram_bus.wen), 1);
      tick(); in_vld = 1'b0; settle();
      chk("t1_out_vld", 64'(out_vld), 0);
      chk("t1_count", 64'(count), 1);
      chk("t1_ren", 64'(ram_bus.ren), 1);
      tick(); settle();
      chk("t2_out_vld", 64'(out_vld), 1);
      chk("t2_out_dat", 64'(out_dat), 64'h123456789ABC);
      out_rdy = 1'b1;
      tick(); out_rdy = 1'b0; settle();
      chk("t3_count", 64'(count), 0);
      chk("t3_out_vld", 64'(out_vld), 0);

      // Fill with the consumer stalled
      acc = 0;
      for (int c = 0; c < 560; c++) begin
         in_vld = 1'b1; in_dat = 48'(acc); settle();
         if (in_rdy) acc++;
         tick();
      end
      in_vld = 1'b0; settle();
      chk("fill_accepted", 64'(acc), 514);
      chk("fill_count", 64'(count), 514);
      chk("fill_in_rdy", 64'(in_rdy), 0);
      chk("fill_ren", 64'(ram_bus.ren), 0);
      chk("fill_head_vld", 64'(out_vld), 1);
      chk("fill_head_dat", 64'(out_dat), 0);
      out_rdy = 1'b1; settle();
      chk("full_pop_in_rdy", 64'(in_rdy), 0);
      exp_i = 0;
      for (int c = 0; c < 600 && exp_i < 514; c++) begin
         if (out_vld) begin
            chk("drain_dat", 64'(out_dat), 64'(exp_i));
            exp_i++;
         end
         tick(); settle();
      end
      out_rdy = 1'b0; settle();
      chk("drain_total", 64'(exp_i), 514);
      chk("drain_count", 64'(count), 0);
      chk("drain_out_vld", 64'(out_vld), 0);

      // Streaming with random backpressure
      pushed = 0; popped = 0; model = 0;
      for (int c = 0; c < 12000 && popped < 2000; c++) begin
         in_vld  = (pushed < 2000);
         in_dat  = {16'hBEEF, 32'(pushed)};
         out_rdy = 1'($urandom_range(0, 1));
         settle();
         chk("stream_count", 64'(count), 64'(model));
         if (out_vld && out_rdy) begin
            chk("stream_dat", 64'(out_dat), 64'({16'hBEEF, 32'(popped)}));
            popped++; model--;
         end
         if (in_vld && in_rdy) begin
            pushed++; model++;
         end
         tick();
      end
      in_vld = 1'b0; out_rdy = 1'b0; settle();
      chk("stream_popped", 64'(popped), 2000);
      chk("stream_end_count", 64'(count), 0);

      // ECC status on words 5 (SBE) and 9 (DBE)
      ecc_en = 1'b1;
      chk("ecc_pre_sbe_cnt", 64'(sbe_cnt), 0);
      chk("ecc_pre_err", 64'(err_dbe), 0);
      for (int k = 0; k < 12; k++) begin
         in_vld = 1'b1; in_dat = 48'(k); settle();
         chk("ecc_push_rdy", 64'(in_rdy), 1);
         tick();
      end
      in_vld = 1'b0; out_rdy = 1'b1; settle();
      e = 0;
      for (int c = 0; c < 100 && e < 12; c++) begin
         if (out_vld) begin
            chk("ecc_dat", 64'(out_dat), 64'(e));
            chk("ecc_sbe", 64'(out_sbe), 64'(e == 5));
            chk("ecc_dbe", 64'(out_dbe), 64'(e == 9));
            if (e == 9) begin
               chk("ecc_sbe_cnt_at9", 64'(sbe_cnt), 1);
               chk("ecc_err_at9", 64'(err_dbe), 0);
            end
            e++;
         end
         tick(); settle();
      end
      out_rdy = 1'b0; ecc_en = 1'b0; settle();
      chk("ecc_pops", 64'(e), 12);
      chk("ecc_sbe_cnt", 64'(sbe_cnt), 1);
      chk("ecc_err_dbe", 64'(err_dbe), 1);

      // Flush with a read in flight and words stored
      for (int k = 0; k < 12; k++) begin
         in_vld = 1'b1; in_dat = 48'(100 + k); settle();
         tick();
      end
      in_vld = 1'b0; out_rdy = 1'b1; settle();
      chk("fl_count12", 64'(count), 12);
      chk("fl_head", 64'(out_dat), 100);
      tick(); out_rdy = 1'b0; settle();
      chk("fl_reissue_ren", 64'(ram_bus.ren), 1);
      chk("fl_count11", 64'(count), 11);
      tick(); flush = 1'b1; settle();
      chk("fl_in_rdy", 64'(in_rdy), 0);
      chk("fl_ren", 64'(ram_bus.ren), 0);
      tick(); flush = 1'b0; settle();
      chk("fl_count", 64'(count), 0);
      chk("fl_out_vld", 64'(out_vld), 0);
      chk("fl_in_rdy_after", 64'(in_rdy), 1);
      chk("fl_wadr", 64'(ram_bus.wadr), 0);
      in_vld = 1'b1; in_dat = 48'hA5; settle();
      tick(); in_vld = 1'b0; out_rdy = 1'b1; settle();
      chk("fl_lat_out_vld", 64'(out_vld), 0);
      tick(); settle();
      chk("fl_a5_vld", 64'(out_vld), 1);
      chk("fl_a5_dat", 64'(out_dat), 64'hA5);
      tick(); out_rdy = 1'b0; settle();
      chk("fl_end_count", 64'(count), 0);
      chk("fl_err_kept", 64'(err_dbe), 1);
      chk("fl_sbe_kept", 64'(sbe_cnt), 1);

      // Asynchronous reset mid-operation
      in_vld = 1'b1; in_dat = 48'h77; settle();
      tick(); in_vld = 1'b0; settle();
      chk("ar_count_pre", 64'(count), 1);
      rst_n = 1'b0; #1;
      chk("ar_count", 64'(count), 0);
      chk("ar_in_rdy", 64'(in_rdy), 0);
      chk("ar_ren", 64'(ram_bus.ren), 0);
      chk("ar_err_dbe", 64'(err_dbe), 0);
      chk("ar_sbe_cnt", 64'(sbe_cnt), 0);
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
